// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer in front of a word-wide RAM.
// IDLE -> ACCESS -> RESP, big-endian byte lanes, LL/SC link bit.
module mem_access_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [3:0]  mem_op_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] load_old_i,
   input  logic [4:0]  wd_i,
   input  logic        flush_i,
   output logic        ram_ce_o,
   output logic        ram_we_o,
   output logic [31:0] ram_addr_o,
   output logic [3:0]  ram_sel_o,
   output logic [31:0] ram_data_o,
   input  logic [31:0] ram_data_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_wdata_o,
   output logic [4:0]  resp_wd_o,
   output logic        resp_wreg_o,
   output logic        addr_err_o,
   output logic        llbit_o
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LB   = 4'd1;
   localparam logic [3:0] OP_LBU  = 4'd2;
   localparam logic [3:0] OP_LH   = 4'd3;
   localparam logic [3:0] OP_LHU  = 4'd4;
   localparam logic [3:0] OP_LW   = 4'd5;
   localparam logic [3:0] OP_LWL  = 4'd6;
   localparam logic [3:0] OP_LWR  = 4'd7;
   localparam logic [3:0] OP_SB   = 4'd8;
   localparam logic [3:0] OP_SH   = 4'd9;
   localparam logic [3:0] OP_SW   = 4'd10;
   localparam logic [3:0] OP_SWL  = 4'd11;
   localparam logic [3:0] OP_SWR  = 4'd12;
   localparam logic [3:0] OP_LL   = 4'd13;
   localparam logic [3:0] OP_SC   = 4'd14;
   localparam logic [3:0] OP_RSVD = 4'd15;

   logic [1:0]  state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] old_q, old_d;
   logic [4:0]  wd_q, wd_d;
   logic        llbit_q, llbit_d;
   logic        ram_ce_q, ram_ce_d;
   logic        ram_we_q, ram_we_d;
   logic [31:0] ram_addr_q, ram_addr_d;
   logic [3:0]  ram_sel_q, ram_sel_d;
   logic [31:0] ram_data_q, ram_data_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_wdata_q, resp_wdata_d;
   logic [4:0]  resp_wd_q, resp_wd_d;
   logic        resp_wreg_q, resp_wreg_d;
   logic        addr_err_q, addr_err_d;

   logic        op_valid;
   logic        misalign;
   logic [1:0]  off_in;
   logic [3:0]  st_sel;
   logic [31:0] st_data;
   logic        st_we;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_res;
   logic        rsp_wreg;

   assign off_in = mem_addr_i[1:0];

   always_comb begin
      op_valid = (mem_op_i != OP_NONE) && (mem_op_i != OP_RSVD);
      misalign = 1'b0;
      if (mem_op_i inside {OP_LH, OP_LHU, OP_SH})
         misalign = off_in[0];
      else if (mem_op_i inside {OP_LW, OP_LL, OP_SW, OP_SC})
         misalign = (off_in != 2'd0);
   end

   // Store lane/data steering, evaluated on the accept cycle.
   always_comb begin
      st_sel  = 4'b1111;
      st_data = store_data_i;
      st_we   = 1'b0;
      case (mem_op_i)
         OP_SB: begin
            st_sel  = 4'b1000 >> off_in;
            st_data = {4{store_data_i[7:0]}};
            st_we   = 1'b1;
         end
         OP_SH: begin
            st_sel  = off_in[1] ? 4'b0011 : 4'b1100;
            st_data = {2{store_data_i[15:0]}};
            st_we   = 1'b1;
         end
         OP_SW: st_we = 1'b1;
         OP_SWL: begin
            st_sel  = 4'b1111 >> off_in;
            st_data = store_data_i >> {off_in, 3'b000};
            st_we   = 1'b1;
         end
         OP_SWR: begin
            st_sel  = 4'b1111 << (2'd3 - off_in);
            st_data = store_data_i << {2'd3 - off_in, 3'b000};
            st_we   = 1'b1;
         end
         OP_SC: st_we = llbit_q;
         default: ;
      endcase
   end

   always_comb begin
      case (off_q)
         2'd0:    ld_byte = ram_data_i[31:24];
         2'd1:    ld_byte = ram_data_i[23:16];
         2'd2:    ld_byte = ram_data_i[15:8];
         default: ld_byte = ram_data_i[7:0];
      endcase
      ld_half = off_q[1] ? ram_data_i[15:0] : ram_data_i[31:16];
      ld_res  = 32'd0;
      case (op_q)
         OP_LB:  ld_res = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU: ld_res = {24'd0, ld_byte};
         OP_LH:  ld_res = {{16{ld_half[15]}}, ld_half};
         OP_LHU: ld_res = {16'd0, ld_half};
         OP_LW, OP_LL: ld_res = ram_data_i;
         OP_LWL: begin
            case (off_q)
               2'd0:    ld_res = ram_data_i;
               2'd1:    ld_res = {ram_data_i[23:0], old_q[7:0]};
               2'd2:    ld_res = {ram_data_i[15:0], old_q[15:0]};
               default: ld_res = {ram_data_i[7:0], old_q[23:0]};
            endcase
         end
         OP_LWR: begin
            case (off_q)
               2'd0:    ld_res = {old_q[31:8], ram_data_i[31:24]};
               2'd1:    ld_res = {old_q[31:16], ram_data_i[31:16]};
               2'd2:    ld_res = {old_q[31:24], ram_data_i[31:8]};
               default: ld_res = ram_data_i;
            endcase
         end
         OP_SC:  ld_res = {31'd0, llbit_q};
         default: ;
      endcase
      rsp_wreg = (op_q inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
                               OP_LWL, OP_LWR, OP_LL, OP_SC});
   end

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      off_d        = off_q;
      old_d        = old_q;
      wd_d         = wd_q;
      llbit_d      = llbit_q;
      ram_ce_d     = 1'b0;
      ram_we_d     = 1'b0;
      ram_addr_d   = 32'd0;
      ram_sel_d    = 4'd0;
      ram_data_d   = 32'd0;
      resp_valid_d = 1'b0;
      resp_wdata_d = 32'd0;
      resp_wd_d    = 5'd0;
      resp_wreg_d  = 1'b0;
      addr_err_d   = 1'b0;
      if (flush_i) begin
         state_d = S_IDLE;
         llbit_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid_i && op_valid) begin
                  op_d  = mem_op_i;
                  off_d = off_in;
                  old_d = load_old_i;
                  wd_d  = wd_i;
                  if (misalign) begin
                     state_d      = S_RESP;
                     resp_valid_d = 1'b1;
                     resp_wd_d    = wd_i;
                     addr_err_d   = 1'b1;
                  end else begin
                     state_d    = S_ACCESS;
                     ram_ce_d   = 1'b1;
                     ram_we_d   = st_we;
                     ram_addr_d = {mem_addr_i[31:2], 2'b00};
                     ram_sel_d  = st_sel;
                     ram_data_d = st_data;
                  end
               end
            end
            S_ACCESS: begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_wd_d    = wd_q;
               resp_wreg_d  = rsp_wreg;
               resp_wdata_d = ld_res;
               if (op_q == OP_LL) llbit_d = 1'b1;
               if (op_q == OP_SC) llbit_d = 1'b0;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         op_q         <= OP_NONE;
         off_q        <= 2'd0;
         old_q        <= 32'd0;
         wd_q         <= 5'd0;
         llbit_q      <= 1'b0;
         ram_ce_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= 32'd0;
         ram_sel_q    <= 4'd0;
         ram_data_q   <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_wdata_q <= 32'd0;
         resp_wd_q    <= 5'd0;
         resp_wreg_q  <= 1'b0;
         addr_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         off_q        <= off_d;
         old_q        <= old_d;
         wd_q         <= wd_d;
         llbit_q      <= llbit_d;
         ram_ce_q     <= ram_ce_d;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_sel_q    <= ram_sel_d;
         ram_data_q   <= ram_data_d;
         resp_valid_q <= resp_valid_d;
         resp_wdata_q <= resp_wdata_d;
         resp_wd_q    <= resp_wd_d;
         resp_wreg_q  <= resp_wreg_d;
         addr_err_q   <= addr_err_d;
      end
   end

   assign req_ready_o  = (state_q == S_IDLE);
   assign ram_ce_o     = ram_ce_q;
   // A reset landing on the ACCESS edge must keep the RAM from committing.
   assign ram_we_o     = ram_we_q & ~rst;
   assign ram_addr_o   = ram_addr_q;
   assign ram_sel_o    = ram_sel_q;
   assign ram_data_o   = ram_data_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_wdata_o = resp_wdata_q;
   assign resp_wd_o    = resp_wd_q;
   assign resp_wreg_o  = resp_wreg_q;
   assign addr_err_o   = addr_err_q;
   assign llbit_o      = llbit_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random load/store traffic against a
// byte-addressed big-endian memory model with an LL/SC link flag.
module tb_mem_access_ctrl;

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LB   = 4'd1;
   localparam logic [3:0] OP_LBU  = 4'd2;
   localparam logic [3:0] OP_LH   = 4'd3;
   localparam logic [3:0] OP_LHU  = 4'd4;
   localparam logic [3:0] OP_LW   = 4'd5;
   localparam logic [3:0] OP_LWL  = 4'd6;
   localparam logic [3:0] OP_LWR  = 4'd7;
   localparam logic [3:0] OP_SB   = 4'd8;
   localparam logic [3:0] OP_SH   = 4'd9;
   localparam logic [3:0] OP_SW   = 4'd10;
   localparam logic [3:0] OP_SWL  = 4'd11;
   localparam logic [3:0] OP_SWR  = 4'd12;
   localparam logic [3:0] OP_LL   = 4'd13;
   localparam logic [3:0] OP_SC   = 4'd14;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [3:0]  mem_op_i;
   logic [31:0] mem_addr_i;
   logic [31:0] store_data_i;
   logic [31:0] load_old_i;
   logic [4:0]  wd_i;
   logic        flush_i;
   logic        ram_ce_o;
   logic        ram_we_o;
   logic [31:0] ram_addr_o;
   logic [3:0]  ram_sel_o;
   logic [31:0] ram_data_o;
   logic [31:0] ram_data_i;
   logic        resp_valid_o;
   logic [31:0] resp_wdata_o;
   logic [4:0]  resp_wd_o;
   logic        resp_wreg_o;
   logic        addr_err_o;
   logic        llbit_o;

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .mem_op_i     (mem_op_i),
      .mem_addr_i   (mem_addr_i),
      .store_data_i (store_data_i),
      .load_old_i   (load_old_i),
      .wd_i         (wd_i),
      .flush_i      (flush_i),
      .ram_ce_o     (ram_ce_o),
      .ram_we_o     (ram_we_o),
      .ram_addr_o   (ram_addr_o),
      .ram_sel_o    (ram_sel_o),
      .ram_data_o   (ram_data_o),
      .ram_data_i   (ram_data_i),
      .resp_valid_o (resp_valid_o),
      .resp_wdata_o (resp_wdata_o),
      .resp_wd_o    (resp_wd_o),
      .resp_wreg_o  (resp_wreg_o),
      .addr_err_o   (addr_err_o),
      .llbit_o      (llbit_o)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0]  ref_b [0:63];
   bit          ll_ref;
   logic [31:0] ram [0:15];
   logic        init_go;

   logic [31:0] obs_res, obs_addr, obs_data;
   logic [3:0]  obs_sel;
   logic        obs_we, obs_err;

   function automatic logic [31:0] ref_word(input int w);
      return {ref_b[4*w], ref_b[4*w+1], ref_b[4*w+2], ref_b[4*w+3]};
   endfunction

   assign ram_data_i = ram[ram_addr_o[5:2]];

   always @(posedge clk) begin
      logic [31:0] nw;
      if (init_go) begin
         for (int w = 0; w < 16; w++) ram[w] <= ref_word(w);
      end else if (ram_ce_o && ram_we_o) begin
         nw = ram[ram_addr_o[5:2]];
         for (int k = 0; k < 4; k++)
            if (ram_sel_o[3-k]) nw[31-8*k -: 8] = ram_data_o[31-8*k -: 8];
         ram[ram_addr_o[5:2]] <= nw;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Transaction-level model: big-endian byte memory, link flag.
   task automatic model_txn(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] old,
                            output logic [31:0] res, output bit err,
                            output bit wreg);
      int off, base, p;
      off  = int'(a[1:0]);
      p    = int'(a[5:0]);
      base = p - off;
      res  = 32'd0;
      err  = 1'b0;
      wreg = 1'b0;
      if (op == OP_NONE || op == 4'd15) return;
      if ((op inside {OP_LH, OP_LHU, OP_SH} && a[0]) ||
          (op inside {OP_LW, OP_LL, OP_SW, OP_SC} && off != 0)) begin
         err = 1'b1;
         return;
      end
      wreg = (op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL,
                         OP_LWR, OP_LL, OP_SC});
      case (op)
         OP_LB:  res = {{24{ref_b[p][7]}}, ref_b[p]};
         OP_LBU: res = {24'd0, ref_b[p]};
         OP_LH:  res = {{16{ref_b[p][7]}}, ref_b[p], ref_b[p+1]};
         OP_LHU: res = {16'd0, ref_b[p], ref_b[p+1]};
         OP_LW:  res = ref_word(base / 4);
         OP_LL: begin
            res = ref_word(base / 4);
            ll_ref = 1'b1;
         end
         OP_LWL: begin
            res = old;
            for (int i = 0; i <= 3 - off; i++) res[31-8*i -: 8] = ref_b[p+i];
         end
         OP_LWR: begin
            res = old;
            for (int j = 0; j <= off; j++) res[8*(off-j)+7 -: 8] = ref_b[base+j];
         end
         OP_SB: ref_b[p] = sd[7:0];
         OP_SH: begin
            ref_b[p]   = sd[15:8];
            ref_b[p+1] = sd[7:0];
         end
         OP_SW: for (int i = 0; i < 4; i++) ref_b[p+i] = sd[31-8*i -: 8];
         OP_SWL: for (int i = 0; i <= 3 - off; i++) ref_b[p+i] = sd[31-8*i -: 8];
         OP_SWR: for (int j = 0; j <= off; j++) ref_b[base+j] = sd[8*(off-j)+7 -: 8];
         OP_SC: begin
            if (ll_ref) begin
               for (int i = 0; i < 4; i++) ref_b[p+i] = sd[31-8*i -: 8];
               res = 32'd1;
            end
            ll_ref = 1'b0;
         end
         default: ;
      endcase
   endtask

   task automatic drive_req(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] old,
                            input logic [4:0] wd);
      req_valid_i  = 1'b1;
      mem_op_i     = op;
      mem_addr_i   = a;
      store_data_i = sd;
      load_old_i   = old;
      wd_i         = wd;
   endtask

   task automatic wait_ready();
      int w;
      w = 0;
      while (!req_ready_o && w < 8) begin
         @(negedge clk);
         w++;
      end
      check_eq("ready_before_req", req_ready_o, 1);
   endtask

   task automatic do_req(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] old,
                         input logic [4:0] wd);
      logic [31:0] eres;
      bit          eerr, ewreg, ewe;
      ewe = (op inside {OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR}) ||
            (op == OP_SC && ll_ref);
      wait_ready();
      drive_req(op, a, sd, old, wd);
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      model_txn(op, a, sd, old, eres, eerr, ewreg);
      obs_we  = 1'b0;
      obs_err = 1'b0;
      if (op == OP_NONE || op == 4'd15) begin
         check_eq("none_ready", req_ready_o, 1);
         check_eq("none_ce", ram_ce_o, 0);
         check_eq("none_resp", resp_valid_o, 0);
         return;
      end
      if (eerr) begin
         check_eq("err_resp_valid", resp_valid_o, 1);
         check_eq("err_flag", addr_err_o, 1);
         check_eq("err_wreg", resp_wreg_o, 0);
         check_eq("err_no_ce", ram_ce_o, 0);
         check_eq("err_wd", resp_wd_o, wd);
         obs_err = addr_err_o;
         obs_res = resp_wdata_o;
         @(negedge clk);
         check_eq("err_resp_drop", resp_valid_o, 0);
      end else begin
         check_eq("acc_ce", ram_ce_o, 1);
         check_eq("acc_we", ram_we_o, ewe);
         check_eq("acc_addr", ram_addr_o, {a[31:2], 2'b00});
         check_eq("acc_ready_low", req_ready_o, 0);
         check_eq("acc_no_resp", resp_valid_o, 0);
         obs_we   = ram_we_o;
         obs_sel  = ram_sel_o;
         obs_data = ram_data_o;
         obs_addr = ram_addr_o;
         @(negedge clk);
         check_eq("resp_valid", resp_valid_o, 1);
         check_eq("resp_wdata", resp_wdata_o, eres);
         check_eq("resp_wreg", resp_wreg_o, ewreg);
         check_eq("resp_wd", resp_wd_o, wd);
         check_eq("resp_no_err", addr_err_o, 0);
         check_eq("resp_no_ce", ram_ce_o, 0);
         check_eq("resp_ready_low", req_ready_o, 0);
         obs_res = resp_wdata_o;
         @(negedge clk);
         check_eq("resp_one_cycle", resp_valid_o, 0);
      end
      check_eq("llbit", llbit_o, ll_ref);
      check_eq("mem_word", ram[a[5:2]], ref_word(int'(a[5:2])));
   endtask

   task automatic flush_idle();
      flush_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush_i = 1'b0;
      ll_ref  = 1'b0;
      check_eq("flush_idle_ll", llbit_o, 0);
      check_eq("flush_idle_ready", req_ready_o, 1);
   endtask

   initial begin
      logic [31:0] eres;
      bit          eerr, ewreg;
      logic [3:0]  op;
      logic [31:0] a;

      rst = 1'b1;
      req_valid_i = 1'b0;
      flush_i = 1'b0;
      mem_op_i = 4'd0;
      mem_addr_i = 32'd0;
      store_data_i = 32'd0;
      load_old_i = 32'd0;
      wd_i = 5'd0;
      ll_ref = 1'b0;
      for (int i = 0; i < 64; i++) ref_b[i] = 8'($urandom);
      ref_b[8]  = 8'h11;
      ref_b[9]  = 8'h22;
      ref_b[10] = 8'h33;
      ref_b[11] = 8'h44;
      init_go = 1'b1;
      @(negedge clk);
      init_go = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      check_eq("rst_ready", req_ready_o, 1);
      check_eq("rst_ce", ram_ce_o, 0);
      check_eq("rst_we", ram_we_o, 0);
      check_eq("rst_sel", ram_sel_o, 0);
      check_eq("rst_resp_valid", resp_valid_o, 0);
      check_eq("rst_addr_err", addr_err_o, 0);
      check_eq("rst_llbit", llbit_o, 0);

      do_req(OP_SB, 32'h5, 32'h0000_00AB, 32'd0, 5'd1);
      check_eq("sb_addr", obs_addr, 32'h4);
      check_eq("sb_sel", obs_sel, 4'b0100);
      check_eq("sb_data", obs_data, 32'hABAB_ABAB);
      check_eq("sb_we", obs_we, 1);

      do_req(OP_LH, 32'hA, 32'd0, 32'd0, 5'd2);
      check_eq("lh_0xA", obs_res, 32'h0000_3344);
      do_req(OP_LB, 32'h8, 32'd0, 32'd0, 5'd3);
      check_eq("lb_0x8", obs_res, 32'h0000_0011);
      do_req(OP_LWL, 32'h9, 32'd0, 32'hAABB_CCDD, 5'd4);
      check_eq("lwl_0x9", obs_res, 32'h2233_44DD);

      do_req(OP_LW, 32'h6, 32'd0, 32'd0, 5'd5);
      check_eq("lw_misalign", obs_err, 1);

      do_req(OP_LL, 32'h10, 32'd0, 32'd0, 5'd6);
      do_req(OP_SC, 32'h10, 32'hCAFE_F00D, 32'd0, 5'd7);
      check_eq("sc1_result", obs_res, 32'd1);
      check_eq("sc1_we", obs_we, 1);
      do_req(OP_SC, 32'h10, 32'h1234_5678, 32'd0, 5'd7);
      check_eq("sc2_result", obs_res, 32'd0);
      check_eq("sc2_we", obs_we, 0);
      do_req(OP_LL, 32'h10, 32'd0, 32'd0, 5'd6);
      flush_idle();
      do_req(OP_SC, 32'h10, 32'h1357_9BDF, 32'd0, 5'd7);
      check_eq("sc_after_flush", obs_res, 32'd0);

      // flush during ACCESS: store commits, no response, link dropped
      do_req(OP_LL, 32'h14, 32'd0, 32'd0, 5'd8);
      wait_ready();
      drive_req(OP_SW, 32'h24, 32'h0BAD_F00D, 32'd0, 5'd9);
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      flush_i = 1'b1;
      model_txn(OP_SW, 32'h24, 32'h0BAD_F00D, 32'd0, eres, eerr, ewreg);
      @(posedge clk);
      @(negedge clk);
      flush_i = 1'b0;
      ll_ref = 1'b0;
      check_eq("flush_acc_no_resp", resp_valid_o, 0);
      check_eq("flush_acc_ready", req_ready_o, 1);
      check_eq("flush_acc_ll", llbit_o, 0);
      check_eq("flush_acc_mem", ram[9], 32'h0BAD_F00D);

      // flush together with a request in IDLE drops it
      drive_req(OP_LW, 32'h8, 32'd0, 32'd0, 5'd10);
      flush_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      flush_i = 1'b0;
      check_eq("flush_req_ready", req_ready_o, 1);
      check_eq("flush_req_ce", ram_ce_o, 0);
      @(negedge clk);
      check_eq("flush_req_resp", resp_valid_o, 0);

      // back-to-back with req_valid held high
      drive_req(OP_LW, 32'h8, 32'd0, 32'd0, 5'd11);
      @(posedge clk);
      @(negedge clk);
      model_txn(OP_LW, 32'h8, 32'd0, 32'd0, eres, eerr, ewreg);
      drive_req(OP_LBU, 32'h9, 32'd0, 32'd0, 5'd12);
      check_eq("b2b_ready_access", req_ready_o, 0);
      @(negedge clk);
      check_eq("b2b_ready_resp", req_ready_o, 0);
      check_eq("b2b_first_valid", resp_valid_o, 1);
      check_eq("b2b_first_data", resp_wdata_o, eres);
      check_eq("b2b_first_lit", resp_wdata_o, 32'h1122_3344);
      @(negedge clk);
      check_eq("b2b_ready_idle", req_ready_o, 1);
      check_eq("b2b_idle_ce", ram_ce_o, 0);
      @(negedge clk);
      req_valid_i = 1'b0;
      model_txn(OP_LBU, 32'h9, 32'd0, 32'd0, eres, eerr, ewreg);
      check_eq("b2b_second_ce", ram_ce_o, 1);
      check_eq("b2b_second_addr", ram_addr_o, 32'h8);
      @(negedge clk);
      check_eq("b2b_second_valid", resp_valid_o, 1);
      check_eq("b2b_second_data", resp_wdata_o, eres);
      check_eq("b2b_second_wd", resp_wd_o, 5'd12);
      @(negedge clk);

      // reset during the ACCESS cycle of a SW
      do_req(OP_LL, 32'h1C, 32'd0, 32'd0, 5'd13);
      wait_ready();
      drive_req(OP_SW, 32'h20, 32'hDEAD_BEEF, 32'd0, 5'd14);
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      check_eq("rst_acc_ce", ram_ce_o, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ll_ref = 1'b0;
      check_eq("rsta_mem", ram[8], ref_word(8));
      check_eq("rsta_ce", ram_ce_o, 0);
      check_eq("rsta_we", ram_we_o, 0);
      check_eq("rsta_addr", ram_addr_o, 0);
      check_eq("rsta_sel", ram_sel_o, 0);
      check_eq("rsta_data", ram_data_o, 0);
      check_eq("rsta_valid", resp_valid_o, 0);
      check_eq("rsta_wdata", resp_wdata_o, 0);
      check_eq("rsta_wd", resp_wd_o, 0);
      check_eq("rsta_wreg", resp_wreg_o, 0);
      check_eq("rsta_err", addr_err_o, 0);
      check_eq("rsta_ll", llbit_o, 0);
      check_eq("rsta_ready", req_ready_o, 1);
      rst = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 300; t++) begin
         if ($urandom_range(0, 19) == 0) flush_idle();
         op = 4'($urandom_range(0, 15));
         a  = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         do_req(op, a, $urandom, $urandom, 5'($urandom));
      end

      for (int w = 0; w < 16; w++) check_eq("final_mem", ram[w], ref_word(w));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 req_valid_i  in  1  memory request from MEM stage.
REQ-005 req_ready_o  out  1  block can accept a request; high only in IDLE.
REQ-006 mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR, 8 SB, 9 SH, 10 SW, 11 SWL, 12 SWR, 13 LL, 14 SC; 15 is treated as NONE.
REQ-007 mem_addr_i  in  32  byte address; store_data_i  in  32  rt value; load_old_i  in  32  old rt for LWL/LWR; wd_i  in  5  destination register.
REQ-008 flush_i  in  1  pipeline flush / exception.
REQ-009 ram_ce_o, ram_we_o  out  1 each; ram_addr_o  out  32  word-aligned, {addr[31:2],2'b00}; ram_sel_o  out  4; ram_data_o  out  32; ram_data_i  in  32  combinational read data.
REQ-010 resp_valid_o  out  1; resp_wdata_o  out  32; resp_wd_o  out  5; resp_wreg_o  out  1; addr_err_o  out  1; llbit_o  out  1.

Function
REQ-011 FSM states SHALL be IDLE, ACCESS, RESP; all outputs SHALL be registered except req_ready_o.
REQ-012 IDLE: on req_valid_i & req_ready_o with an op other than NONE, latch op/addr/data/old/wd; a NONE op SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-013 Misalignment: a halfword op with addr[0]=1, or a LW/LL/SW/SC op with addr[1:0]!=0, SHALL go to RESP with no RAM access, addr_err_o=1 and resp_wreg_o=0.
REQ-014 Aligned request: go to ACCESS for exactly one cycle with ram_ce_o=1; stores SHALL drive ram_we_o=1, so the write commits at the clock edge that ends ACCESS.
REQ-015 Byte lanes are big-endian: offset 0 maps to sel[3] and data[31:24]. SB: sel=4'b1000>>off, data={4{b}}. SH: sel=off?0011:1100, data={2{h}}. SW/SC: sel=1111.
REQ-016 SWL: sel=4'b1111>>off, data=store>>(8*off). SWR: sel=(4'b1111<<(3-off)) truncated to 4 bits, data=store<<(8*(3-off)).
REQ-017 Loads SHALL sample ram_data_i (W) at the end of ACCESS. LB/LBU/LH/LHU: select the lane per REQ-015, then sign-extend or zero-extend to 32 bits. LW/LL: W.
REQ-018 LWL by offset 0..3: W, {W[23:0],old[7:0]}, {W[15:0],old[15:0]}, {W[7:0],old[23:0]}.
REQ-019 LWR by offset 0..3: {old[31:8],W[31:24]}, {old[31:16],W[31:16]}, {old[31:24],W[31:8]}, W.
REQ-020 RESP: resp_valid_o=1 for exactly one cycle with resp_wd_o=wd. resp_wreg_o=1 for loads, LL and SC; 0 for other stores and errors. Then go to IDLE.
REQ-021 LL SHALL set llbit. SC with llbit=1 SHALL write like SW and return 1; SC with llbit=0 SHALL keep ram_we_o=0 and return 0. Any SC SHALL clear llbit at the end of ACCESS.
REQ-022 Load latency: accept edge -> ACCESS -> RESP, so resp_valid_o rises 2 cycles after acceptance. Throughput is one request per 3 cycles.
REQ-023 flush_i in any state SHALL clear llbit and force IDLE on the next edge, and resp_valid_o SHALL be 0 in that next cycle. A store already in ACCESS SHALL still commit.
REQ-024 flush_i and req_valid_i in the same IDLE cycle: the request SHALL be dropped.
REQ-025 Outside ACCESS: ram_ce_o=0, ram_we_o=0, ram_sel_o=0.

Reset
REQ-026 rst SHALL force IDLE and llbit=0. All registered outputs SHALL become 0: resp_*, addr_err_o, ram_* and llbit_o.
REQ-027 rst SHALL take priority over flush_i and req_valid_i. Reset during ACCESS SHALL suppress the pending write at that edge.

Verification
REQ-028 SB addr 0x0000_0005, data 0x0000_00AB -> ACCESS cycle: ram_addr 0x4, sel 0100, data 0xABABABAB, we=1.
REQ-029 Memory word 0x1122_3344 at 0x8. LH addr 0xA -> resp_wdata 0x0000_3344. LB addr 0x8 -> 0x0000_0011. LWL addr 0x9, old 0xAABBCCDD -> 0x223344DD.
REQ-030 LW addr 0x6 -> no ram_ce. Next cycle: resp_valid=1, addr_err=1, resp_wreg=0.
REQ-031 LL 0x10, then SC 0x10 -> SC writes, result 1. A second SC -> no write, result 0. LL, then flush, then SC -> result 0.
REQ-032 Back-to-back requests with req_valid_i held high -> req_ready_o low in ACCESS/RESP; the second request is accepted only on return to IDLE.
REQ-033 Reset asserted in ACCESS of an SW -> no write, all outputs 0 next cycle.
